// File: rtl/cpu_mem_io.sv
// CPU-side memory/IO slave: combinational-read data RAM, memory-mapped TX FIFO,
// STATUS register and optional free-running timer (enabled by CPU_MEM_IO_TIMER_EN).
module cpu_mem_io #(
  parameter int unsigned RAM_DEPTH  = 240,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] AddressBus,
  input  logic [7:0] WriteDataBus,
  input  logic       MemwriteEnable,
  output logic [7:0] ReadDataBus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [7:0] ADDR_TXDATA = 8'hF0;
  localparam logic [7:0] ADDR_STATUS = 8'hF1;
  localparam logic [7:0] ADDR_TIMER  = 8'hF2;

  logic [7:0] ram_q  [RAM_DEPTH];
  logic [7:0] fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
`ifdef CPU_MEM_IO_TIMER_EN
  logic [7:0]       timer_q, timer_d;
`endif

  logic       ram_hit, ram_we;
  logic       empty, full, pop;
  logic       push_req, push_ok, fifo_we;
  logic       ovf_clr;
  logic [3:0] count_sat;
  logic [7:0] status;

  // Decode and FIFO handshake qualification
  always_comb begin
    ram_hit   = 32'(AddressBus) < RAM_DEPTH;
    ram_we    = reset && MemwriteEnable && ram_hit;
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = !empty && tx_ready;
    push_req  = MemwriteEnable && (AddressBus == ADDR_TXDATA);
    push_ok   = push_req && (!full || pop);
    fifo_we   = reset && push_ok;
    ovf_clr   = MemwriteEnable && (AddressBus == ADDR_STATUS) && WriteDataBus[2];
    count_sat = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
    status    = {count_sat, 1'b0, ovf_q, full, empty};
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A dropped push outranks a clear; both cannot come from one bus cycle anyway
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
  end

`ifdef CPU_MEM_IO_TIMER_EN
  always_comb begin
    timer_d = timer_q + 8'd1;
    if (MemwriteEnable && (AddressBus == ADDR_TIMER)) timer_d = WriteDataBus;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef CPU_MEM_IO_TIMER_EN
      timer_q  <= 8'h00;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
`ifdef CPU_MEM_IO_TIMER_EN
      timer_q  <= timer_d;
`endif
    end
  end

  // Storage arrays are never cleared; reset only blocks the same-cycle write
  always_ff @(posedge clk) begin
    if (ram_we)  ram_q[RAM_AW'(AddressBus)] <= WriteDataBus;
    if (fifo_we) fifo_q[wr_ptr_q]           <= WriteDataBus;
  end

  always_comb begin
    ReadDataBus = 8'h00;
    if (ram_hit) begin
      ReadDataBus = ram_q[RAM_AW'(AddressBus)];
    end else begin
      case (AddressBus)
        ADDR_STATUS: ReadDataBus = status;
`ifdef CPU_MEM_IO_TIMER_EN
        ADDR_TIMER:  ReadDataBus = timer_q;
`endif
        default:     ReadDataBus = 8'h00;
      endcase
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_cpu_mem_io.sv
// Bench for cpu_mem_io: queue/array reference model checked every cycle plus
// directed literal expectations. Follows CPU_MEM_IO_TIMER_EN like the design.
module tb_cpu_mem_io;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] AddressBus = 8'h00;
  logic [7:0] WriteDataBus = 8'h00;
  logic       MemwriteEnable = 1'b0;
  logic [7:0] ReadDataBus;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  cpu_mem_io #(.RAM_DEPTH(240), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .AddressBus(AddressBus), .WriteDataBus(WriteDataBus),
    .MemwriteEnable(MemwriteEnable), .ReadDataBus(ReadDataBus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [7:0] q_m[$];
  bit         ovf_m = 1'b0;
  int         timer_m = 0;
  logic [7:0] ram_m [240];
  bit         ram_known [240];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] status_m();
    int c;
    c = (q_m.size() > 15) ? 15 : q_m.size();
    return {4'(c), 1'b0, ovf_m, (q_m.size() == DEPTH), (q_m.size() == 0)};
  endfunction

  function automatic void model_read(input logic [7:0] a, output logic [7:0] v, output bit known);
    known = 1'b1;
    v = 8'h00;
    if (a < 8'd240) begin
      known = ram_known[a];
      v = ram_m[a];
    end else if (a == 8'hF1) begin
      v = status_m();
    end else if (a == 8'hF2) begin
`ifdef CPU_MEM_IO_TIMER_EN
      v = 8'(timer_m);
`else
      v = 8'h00;
`endif
    end
  endfunction

  always @(posedge clk) begin
    bit pop, push;
    int sz;
    if (!reset) begin
      q_m.delete();
      ovf_m = 1'b0;
      timer_m = 0;
    end else begin
      sz   = q_m.size();
      pop  = (sz != 0) && tx_ready;
      push = MemwriteEnable && (AddressBus == 8'hF0);
      if (pop) void'(q_m.pop_front());
      if (push) begin
        if (sz < DEPTH || pop) q_m.push_back(WriteDataBus);
        else                   ovf_m = 1'b1;
      end
      if (MemwriteEnable && AddressBus == 8'hF1 && WriteDataBus[2] && !(push && !(sz < DEPTH || pop)))
        ovf_m = 1'b0;
      if (MemwriteEnable && AddressBus == 8'hF2) timer_m = WriteDataBus;
      else                                       timer_m = (timer_m + 1) % 256;
      if (MemwriteEnable && AddressBus < 8'd240) begin
        ram_m[AddressBus] = WriteDataBus;
        ram_known[AddressBus] = 1'b1;
      end
    end
  end

  // Continuous comparison against the model, mid-cycle
  always @(negedge clk) begin
    logic [7:0] v;
    bit kn;
    if (check_en) begin
      model_read(AddressBus, v, kn);
      if (kn) chk("model_rdata", ReadDataBus, v);
      chk("model_tx_valid", 8'(tx_valid), 8'(q_m.size() != 0));
      if (q_m.size() != 0) chk("model_tx_data", tx_data, q_m[0]);
    end
  end

  task automatic set_in(input logic [7:0] a, input logic [7:0] w, input logic we, input logic rdy);
    AddressBus = a; WriteDataBus = w; MemwriteEnable = we; tx_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] w, input logic rdy);
    set_in(a, w, 1'b1, rdy); tick();
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
    set_in(a, 8'h00, 1'b0, 1'b0);
    @(negedge clk); chk(nm, ReadDataBus, exp);
  endtask

  logic [7:0] exp7 [8];

  initial begin
    for (int i = 0; i < 240; i++) ram_known[i] = 1'b0;
    exp7 = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};

    // Reset
    set_in(8'hF1, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b1;
    check_en = 1'b1;
    rd_chk("reset_status", 8'hF1, 8'h01);
    chk("reset_tx_valid", 8'(tx_valid), 8'h00);
    tick();

    // RAM write, same-cycle read returns old data
    wr(8'h10, 8'h3C, 1'b0);
    set_in(8'h10, 8'hA5, 1'b1, 1'b0);
    @(negedge clk); chk("ram_old_on_write", ReadDataBus, 8'h3C);
    tick();
    rd_chk("ram_read", 8'h10, 8'hA5); tick();

    // Fill and overflow
    for (int i = 1; i <= 8; i++) wr(8'hF0, 8'(i), 1'b0);
    rd_chk("fill_status", 8'hF1, 8'h82);
    chk("fill_head", tx_data, 8'h01);
    tick();
    wr(8'hF0, 8'h09, 1'b0);
    rd_chk("ovf_status", 8'hF1, 8'h86);
    chk("ovf_head", tx_data, 8'h01);
    tick();
    wr(8'hF1, 8'h04, 1'b0);
    rd_chk("ovf_clear", 8'hF1, 8'h82); tick();

    // Drain order
    for (int i = 0; i < 8; i++) begin
      set_in(8'hF1, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      chk("drain_data", tx_data, 8'(i + 1));
      chk("drain_valid", 8'(tx_valid), 8'h01);
      tick();
    end
    rd_chk("drain_status", 8'hF1, 8'h01);
    chk("drain_empty", 8'(tx_valid), 8'h00);
    tick();

    // Push and pop on full
    for (int i = 0; i < 8; i++) wr(8'hF0, 8'(8'h11 + i), 1'b0);
    set_in(8'hF0, 8'h55, 1'b1, 1'b1);
    @(negedge clk); chk("pp_head", tx_data, 8'h11);
    tick();
    rd_chk("pp_status", 8'hF1, 8'h82); tick();
    for (int i = 0; i < 8; i++) begin
      set_in(8'hF1, 8'h00, 1'b0, 1'b1);
      @(negedge clk); chk("pp_order", tx_data, exp7[i]);
      tick();
    end
    rd_chk("pp_done", 8'hF1, 8'h01); tick();

    // Timer
`ifdef CPU_MEM_IO_TIMER_EN
    wr(8'hF2, 8'hFE, 1'b0);
    rd_chk("timer_fe", 8'hF2, 8'hFE); tick();
    rd_chk("timer_ff", 8'hF2, 8'hFF); tick();
    rd_chk("timer_wrap", 8'hF2, 8'h00); tick();
`else
    wr(8'hF2, 8'hFE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rd_chk("timer_absent", 8'hF2, 8'h00); tick();
    end
`endif

    // Reset mid-traffic: 3 queued, overflow set
    for (int i = 1; i <= 9; i++) wr(8'hF0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      set_in(8'hF1, 8'h00, 1'b0, 1'b1); tick();
    end
    rd_chk("pre_reset_status", 8'hF1, 8'h34);
    chk("pre_reset_head", tx_data, 8'h26);
    tick();
    reset = 1'b0;
    wr(8'hF0, 8'h77, 1'b0);
    reset = 1'b1;
    rd_chk("post_reset_status", 8'hF1, 8'h01);
    chk("post_reset_valid", 8'(tx_valid), 8'h00);
    tick();
    wr(8'hF0, 8'h42, 1'b0);
    set_in(8'hF1, 8'h00, 1'b0, 1'b0);
    @(negedge clk); chk("post_reset_push", tx_data, 8'h42);
    chk("post_reset_count", ReadDataBus, 8'h10);
    tick();

    // Mixed traffic checked by the model only
    for (int n = 0; n < 80; n++) begin
      logic [7:0] a;
      case ($urandom_range(0, 5))
        0, 1:    a = 8'hF0;
        2:       a = 8'hF1;
        3:       a = 8'hF2;
        4:       a = 8'(8'h20 + $urandom_range(0, 3));
        default: a = 8'hF7;
      endcase
      set_in(a, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
